// File: rtl/ram_copy_engine.sv
// ram_copy_engine: read-then-write block copy sequencer driving a single-port RAM.
// Overlapping copies choose a descending order so source words are read before
// they are overwritten. Optional macro COPY_CHECKSUM_EN adds a running sum of
// every word read, exposed on the `checksum` output.
module ram_copy_engine #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_src, w_src_nxt;
  logic [ADDR_W-1:0]   r_dst, w_dst_nxt;
  logic [LEN_W-1:0]    r_rem, w_rem_nxt;
  logic                r_desc, w_desc_nxt;
  logic [DATA_W-1:0]   r_buf, w_buf_nxt;
  logic                r_err, w_err_nxt;
  logic [DATA_W-1:0]   r_cks, w_cks_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_ram_ena, w_ram_ena_nxt;
  logic                r_ram_wena, w_ram_wena_nxt;
  logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr_nxt;

  logic                w_accept;
  logic                w_len_bad;
  logic                w_len_zero;
  logic [ADDR_W-1:0]   w_diff;
  logic [ADDR_W-1:0]   w_len_m1;
  logic                w_desc;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_len_bad  = len > LEN_W'(DEPTH);
  assign w_len_zero = len == '0;
  assign w_diff     = dst_addr - src_addr;
  assign w_len_m1   = ADDR_W'(len - LEN_W'(1));
  // Descending when the destination starts inside the source window.
  assign w_desc     = (dst_addr != src_addr) && ({1'b0, w_diff} < len);

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign ram_ena   = r_ram_ena;
  assign ram_wena  = r_ram_wena;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_buf;
`ifdef COPY_CHECKSUM_EN
  assign checksum  = r_cks;
`endif

  // State, datapath and registered-output storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_rem      <= '0;
      r_desc     <= 1'b0;
      r_buf      <= '0;
      r_err      <= 1'b0;
      r_cks      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ram_ena  <= 1'b0;
      r_ram_wena <= 1'b0;
      r_ram_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_src      <= w_src_nxt;
      r_dst      <= w_dst_nxt;
      r_rem      <= w_rem_nxt;
      r_desc     <= w_desc_nxt;
      r_buf      <= w_buf_nxt;
      r_err      <= w_err_nxt;
      r_cks      <= w_cks_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_ram_ena  <= w_ram_ena_nxt;
      r_ram_wena <= w_ram_wena_nxt;
      r_ram_addr <= w_ram_addr_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (w_len_zero || w_len_bad) ? S_DONE : S_READ;
      S_READ:  w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = (r_rem == LEN_W'(1)) ? S_DONE : S_READ;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath update: latch request, capture read data, step pointers.
  always_comb begin
    w_src_nxt  = r_src;
    w_dst_nxt  = r_dst;
    w_rem_nxt  = r_rem;
    w_desc_nxt = r_desc;
    w_buf_nxt  = r_buf;
    w_err_nxt  = r_err;
    w_cks_nxt  = r_cks;
    if (w_accept) begin
      w_src_nxt  = w_desc ? src_addr + w_len_m1 : src_addr;
      w_dst_nxt  = w_desc ? dst_addr + w_len_m1 : dst_addr;
      w_rem_nxt  = len;
      w_desc_nxt = w_desc;
      w_err_nxt  = w_len_bad;
      w_cks_nxt  = '0;
    end else if (r_state == S_READ) begin
      w_buf_nxt = ram_rdata;
      w_cks_nxt = r_cks + ram_rdata;
    end else if (r_state == S_WRITE) begin
      w_src_nxt = r_desc ? r_src - ADDR_W'(1) : r_src + ADDR_W'(1);
      w_dst_nxt = r_desc ? r_dst - ADDR_W'(1) : r_dst + ADDR_W'(1);
      w_rem_nxt = r_rem - LEN_W'(1);
    end
  end

  // Outputs for the upcoming state, registered at the same edge as the state.
  always_comb begin
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_ram_ena_nxt  = 1'b0;
    w_ram_wena_nxt = 1'b0;
    w_ram_addr_nxt = '0;
    case (w_state_nxt)
      S_READ: begin
        w_busy_nxt     = 1'b1;
        w_ram_ena_nxt  = 1'b1;
        w_ram_addr_nxt = w_src_nxt;
      end
      S_WRITE: begin
        w_busy_nxt     = 1'b1;
        w_ram_ena_nxt  = 1'b1;
        w_ram_wena_nxt = 1'b1;
        w_ram_addr_nxt = w_dst_nxt;
      end
      S_DONE:  w_done_nxt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Self-checking bench for ram_copy_engine: RAM model, memmove reference model,
// directed table, corner sequences and randomized copies.
module tb_ram_copy_engine;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [AW:0]   len;
  logic          busy, done, err, ram_ena, ram_wena;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
`ifdef COPY_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  ram_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef COPY_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // RAM model: bulk preload port plus the single port driven by the DUT.
  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] pl_img [DEPTH];
  logic          pl_load;
  always @(posedge clk) begin
    if (pl_load) for (int i = 0; i < DEPTH; i++) mem[i] <= pl_img[i];
    else if (ram_ena && ram_wena) mem[ram_addr] <= ram_wdata;
  end
  always_comb ram_rdata = (ram_ena && !ram_wena) ? mem[ram_addr] : '0;

  logic [DW-1:0] exp_mem [DEPTH];
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0]       src, dst;
    logic [5:0]       len;
    logic [4:0]       pre_at;
    logic [3:0][31:0] pre;
    int               npre;
    bit               chk_wa;
    logic [4:0]       exp_wa;
    int               exp_done;
    logic             exp_err;
    bit               nudge;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] s, input logic [4:0] d, input logic [5:0] l,
                              input logic [4:0] at, input int n, input logic [31:0] p0,
                              input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                              input bit cw, input logic [4:0] wa, input int dn, input logic e,
                              input bit ng);
    vec_t v;
    v.src = s; v.dst = d; v.len = l; v.pre_at = at; v.npre = n;
    v.pre[0] = p0; v.pre[1] = p1; v.pre[2] = p2; v.pre[3] = p3;
    v.chk_wa = cw; v.exp_wa = wa; v.exp_done = dn; v.exp_err = e; v.nudge = ng;
    return v;
  endfunction

  // Load pl_img into the RAM and the reference copy.
  task automatic load_image();
    @(negedge clk); pl_load = 1'b1;
    @(negedge clk); pl_load = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = pl_img[i];
  endtask

  // Reference: memmove of len words on a ring of DEPTH words; returns sum of words read.
  task automatic model_copy(input logic [4:0] s, input logic [4:0] d, input logic [5:0] l,
                            output logic [31:0] sum);
    logic [DW-1:0] snap [DEPTH];
    for (int i = 0; i < DEPTH; i++) snap[i] = exp_mem[i];
    sum = '0;
    if (l != 0 && l <= 6'(DEPTH))
      for (int i = 0; i < int'(l); i++) begin
        exp_mem[5'(int'(d) + i)] = snap[5'(int'(s) + i)];
        sum += snap[5'(int'(s) + i)];
      end
  endtask

  task automatic check_mem(input string tag);
    int nbad = 0;
    int first = -1;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== exp_mem[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    if (nbad != 0) $display("  %s first bad word %0d: %0h vs %0h", tag, first,
                            mem[first], exp_mem[first]);
    check({tag, " mem_bad_words"}, 64'(nbad), 64'd0);
  endtask

  // Issue one copy and check timing, RAM activity, err, checksum and memory.
  task automatic run_copy(input string tag, input logic [4:0] s, input logic [4:0] d,
                          input logic [5:0] l, input bit nudge, input bit chk_wa,
                          input logic [4:0] exp_wa, input int exp_done, input logic exp_err);
    int cyc = 1;
    int done_cyc = 0;
    int busy_cnt = 0;
    int ena_cnt = 0;
    bit wa_seen = 0;
    logic [4:0] first_wa = '0;
    logic err_at_done = 1'b0;
    logic [31:0] sum;
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = l;
    @(negedge clk);
    start = 1'b0;
    while (done_cyc == 0 && cyc < 200) begin
      if (busy) busy_cnt++;
      if (ram_ena) ena_cnt++;
      if (ram_ena && ram_wena && !wa_seen) begin wa_seen = 1; first_wa = ram_addr; end
      if (done) begin done_cyc = cyc; err_at_done = err; end
      if (nudge) begin
        if (cyc == 2 || done) begin
          start = 1'b1; src_addr = s ^ 5'd5; dst_addr = d ^ 5'd9; len = 6'd7;
        end else start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    model_copy(s, d, l, sum);
    check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_done - 1));
    check({tag, " ram_access_cycles"}, 64'(ena_cnt), 64'(exp_done - 1));
    check({tag, " err"}, 64'(err_at_done), 64'(exp_err));
    if (chk_wa) check({tag, " first_write_addr"}, 64'(first_wa), 64'(exp_wa));
    check({tag, " idle_after_done"}, {61'd0, done, busy, ram_ena}, 64'd0);
`ifdef COPY_CHECKSUM_EN
    check({tag, " checksum"}, 64'(checksum), 64'(sum));
`endif
    check_mem(tag);
  endtask

  initial begin
    logic [4:0] s, d;
    logic [5:0] l;
    int kind, dn;
    int done_seen;
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0; pl_load = 1'b0;
    for (int i = 0; i < DEPTH; i++) pl_img[i] = '0;

    repeat (2) @(negedge clk);
    check("reset outputs", {21'd0, busy, done, err, ram_ena, ram_wena, ram_addr, ram_wdata},
          64'd0);
`ifdef COPY_CHECKSUM_EN
    check("reset checksum", 64'(checksum), 64'd0);
`endif
    rst_n = 1'b1;

    //         src    dst    len    at     n  p0            p1            p2            p3  wa? wa     done err nudge
    tbl[0] = mk(5'd2,  5'd10, 6'd3,  5'd2,  3, 32'h87654321, 32'hABCDEF01, 32'h11223344, 0, 1, 5'd10, 7,   0, 0);
    tbl[1] = mk(5'd0,  5'd1,  6'd4,  5'd0,  4, 32'd1,        32'd2,        32'd3,        4, 1, 5'd4,  9,   0, 0);
    tbl[2] = mk(5'd30, 5'd5,  6'd3,  5'd30, 3, 32'hA,        32'hB,        32'hC,        0, 1, 5'd5,  7,   0, 0);
    tbl[3] = mk(5'd4,  5'd9,  6'd0,  5'd0,  0, 0,            0,            0,            0, 0, 5'd0,  1,   0, 0);
    tbl[4] = mk(5'd4,  5'd9,  6'd33, 5'd0,  0, 0,            0,            0,            0, 0, 5'd0,  1,   1, 0);
    tbl[5] = mk(5'd7,  5'd7,  6'd5,  5'd0,  0, 0,            0,            0,            0, 1, 5'd7,  11,  0, 1);
    tbl[6] = mk(5'd1,  5'd0,  6'd5,  5'd0,  0, 0,            0,            0,            0, 1, 5'd0,  11,  0, 0);
    tbl[7] = mk(5'd28, 5'd30, 6'd4,  5'd0,  0, 0,            0,            0,            0, 1, 5'd1,  9,   0, 0);
    tbl[8] = mk(5'd20, 5'd24, 6'd3,  5'd20, 3, 32'd1,        32'd2,        32'hFFFFFFFF, 0, 1, 5'd24, 7,   0, 0);

    for (int t = 0; t < 9; t++) begin
      for (int i = 0; i < DEPTH; i++) pl_img[i] = $urandom;
      for (int k = 0; k < tbl[t].npre; k++) pl_img[5'(int'(tbl[t].pre_at) + k)] = tbl[t].pre[k];
      load_image();
      run_copy($sformatf("vec%0d", t), tbl[t].src, tbl[t].dst, tbl[t].len, tbl[t].nudge,
               tbl[t].chk_wa, tbl[t].exp_wa, tbl[t].exp_done, tbl[t].exp_err);
    end
`ifdef COPY_CHECKSUM_EN
    check("checksum 1+2+FFFFFFFF", 64'(checksum), 64'h2);
`endif

    // Reset during the second WRITE of a len=4 copy.
    for (int i = 0; i < DEPTH; i++) pl_img[i] = $urandom;
    load_image();
    @(negedge clk);
    start = 1'b1; src_addr = 5'd0; dst_addr = 5'd8; len = 6'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort in 2nd write", {62'd0, ram_ena, ram_wena}, 64'd3);
    rst_n = 1'b0;
    #1;
    check("abort outputs", {61'd0, ram_ena, busy, done}, 64'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort no done", 64'(done_seen), 64'd0);
    rst_n = 1'b1;
    exp_mem[8] = exp_mem[0];
    check_mem("abort");
    run_copy("after_abort", 5'd3, 5'd17, 6'd6, 0, 1, 5'd17, 13, 1'b0);

    // Randomized copies checked against the memmove model.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < DEPTH; i++) pl_img[i] = $urandom;
      load_image();
      kind = int'($urandom_range(0, 9));
      s = 5'($urandom);
      d = 5'($urandom);
      if (kind == 0) l = 6'd0;
      else if (kind == 1) l = 6'($urandom_range(33, 63));
      else if (kind == 2) begin d = s; l = 6'($urandom_range(1, 32)); end
      else l = 6'($urandom_range(1, 16));
      dn = (l == 0 || l > 6'd32) ? 1 : 2 * int'(l) + 1;
      run_copy($sformatf("rnd%0d", n), s, d, l, 0, 0, 5'd0, dn, l > 6'd32);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
